stc_frame_assembler: RTL and testbench
======================================

Name: stc_frame_assembler

Overview:
- Transmit-side counterpart of the STC demod frame aligner: buffers data samples and emits complete frames (pilot block followed by data block) at a fixed output cadence.
- Marks the first pilot sample of each frame with startOfFrame, so a receiver's frame aligner sees the same structure.
- Sits between the STC encoder/modulator sample source and the transmit interpolator.
- Pilot samples come from an external 1-cycle-latency ROM addressed by this block.

Parameters:
- PILOT_LEN, 128: pilot samples per frame.
- DATA_LEN, 3200: data samples per frame.
- CLKS_PER_OUTPUT, 4: clkEn cycles per output sample; must be at least 2.
- ADDR_WIDTH, 12: sample FIFO depth is 2^ADDR_WIDTH.
- PRIME_LEVEL, 3200: FIFO occupancy required to start a frame from IDLE.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets)
- clkEn  in  1  clock enable; all state advances only when high (reset excepted)
- enable  in  1  permit frame generation
- valid  in  1  input sample strobe, qualified by clkEn
- dinReal  in  18  signed input sample, I
- dinImag  in  18  signed input sample, Q
- pilotReal  in  18  signed pilot ROM data, I; valid 1 clk after pilotAddr
- pilotImag  in  18  signed pilot ROM data, Q
- pilotAddr  out  log2(PILOT_LEN)  registered pilot ROM address
- clkEnOut  out  1  one-clock output sample strobe
- startOfFrame  out  1  high with clkEnOut on the first pilot sample of a frame
- doutReal  out  18  registered output sample, I
- doutImag  out  18  registered output sample, Q
- full  out  1  FIFO holds 2^ADDR_WIDTH-1 samples
- overflow  out  1  sticky: write dropped because FIFO was full
- underflow  out  1  sticky: data slot occurred with FIFO empty

Behaviour:
- Reset (reset==0 at clk edge): all outputs 0, FIFO pointers and occupancy 0, state IDLE, decimation counter CLKS_PER_OUTPUT-1. Reset mid-frame aborts the frame immediately; there is no partial-frame completion.

FIFO:
- Write when clkEn&valid&~full. clkEn&valid&full drops the sample and sets overflow.
- Occupancy counter +1 on write, -1 on data read, unchanged on a simultaneous write and read. Pointers wrap modulo 2^ADDR_WIDTH.
- full is registered and equals (occupancy==2^ADDR_WIDTH-1).
- RAM read latency is 1. Read data must be stable by the next strobe.

Cadence:
- Outside IDLE, the decimation counter decrements on each clkEn.
- At 0 it reloads to CLKS_PER_OUTPUT-1 and generates a strobe. clkEnOut = strobe & clkEn, one clock wide.
- dout* and startOfFrame are registered on the strobe clock and held until the next strobe.

State machine (IDLE, PILOT, DATA):
- IDLE: clkEnOut=0. When enable & occupancy>=PRIME_LEVEL, go to PILOT. The first strobe occurs CLKS_PER_OUTPUT clkEn cycles later, and pilotAddr is 0 on entry.
- PILOT:
  - On each strobe, dout = pilot data and pilotAddr increments.
  - startOfFrame=1 only when pilotAddr==0.
  - After strobe number PILOT_LEN: pilotAddr returns to 0 and the state goes to DATA.
- DATA:
  - On each strobe, dout = FIFO head and the read pointer increments.
  - If the FIFO is empty at a strobe: dout=0, pointer unchanged, underflow set, and the slot still counts.
  - After DATA_LEN strobes: go to PILOT if enable, else IDLE. Back-to-back frames have no gap in strobe cadence.
- enable deasserted mid-frame: the current frame completes.
- overflow and underflow clear only on reset.

Test Plan:
- Params PILOT_LEN=4, DATA_LEN=8, CLKS_PER_OUTPUT=4, PRIME_LEVEL=8, ROM[n]=100+n. Write samples 1..8, enable=1, clkEn=1 -> 12 clkEnOut strobes exactly 4 clks apart; dout 100,101,102,103,1..8; startOfFrame only on the 100 strobe; underflow=0.
- Same setup with 16 samples, enable held -> second frame starts on the strobe immediately after sample 8 (4 clks later) with startOfFrame=1, data 9..16.
- Prime with 8 samples and supply none thereafter, enable held -> frame 2 data slots output 0 and underflow=1 at its first data strobe.
- ADDR_WIDTH=4, write 16 samples with no reads -> full=1 after the 15th write; 16th dropped; overflow=1; occupancy 15.
- clkEn toggling 50% -> strobe spacing is 4 clkEn-high cycles and the output sequence is unchanged.
- Assert reset mid-PILOT -> next clock: all outputs 0, state IDLE; re-prime yields a clean frame starting at pilot 100.

Source files
------------

// File: rtl/stc_frame_assembler.sv
// Transmit frame assembler: buffers data samples in a FIFO and emits pilot+data frames
// at a fixed strobe cadence, flagging the first pilot sample with startOfFrame.
module stc_frame_assembler #(
    parameter int PILOT_LEN       = 128,
    parameter int DATA_LEN        = 3200,
    parameter int CLKS_PER_OUTPUT = 4,
    parameter int ADDR_WIDTH      = 12,
    parameter int PRIME_LEVEL     = 3200,
    localparam int PA_W = (PILOT_LEN > 1) ? $clog2(PILOT_LEN) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clkEn,
    input  logic                enable,
    input  logic                valid,
    input  logic signed [17:0]  dinReal,
    input  logic signed [17:0]  dinImag,
    input  logic signed [17:0]  pilotReal,
    input  logic signed [17:0]  pilotImag,
    output logic [PA_W-1:0]     pilotAddr,
    output logic                clkEnOut,
    output logic                startOfFrame,
    output logic signed [17:0]  doutReal,
    output logic signed [17:0]  doutImag,
    output logic                full,
    output logic                overflow,
    output logic                underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int DC_W  = $clog2(CLKS_PER_OUTPUT);
    localparam int DN_W  = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

    typedef enum logic [1:0] {IDLE, PILOT, DATA} state_t;

    state_t                 state_reg;
    logic [DC_W-1:0]        dec_cnt_reg;
    logic [PA_W-1:0]        pilot_addr_reg;
    logic [DN_W-1:0]        data_cnt_reg;
    logic [ADDR_WIDTH-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_WIDTH-1:0]  occ_reg, occ_next;
    logic                   full_reg, overflow_reg, underflow_reg;
    logic                   clk_en_out_reg, sof_reg;
    logic signed [17:0]     dout_re_reg, dout_im_reg;

    logic [35:0]            mem [DEPTH];
    logic [35:0]            ram_q_reg, bypass_data_reg;
    logic                   bypass_reg;
    logic [35:0]            head;

    logic wr_en, rd_en, strobe, empty;

    assign wr_en  = clkEn & valid & ~full_reg;
    assign strobe = clkEn && (state_reg != IDLE) && (dec_cnt_reg == '0);
    assign empty  = (occ_reg == '0);
    assign rd_en  = strobe && (state_reg == DATA) && !empty;

    // A write landing on the address being read is forwarded, since the RAM returns old data.
    assign head = bypass_reg ? bypass_data_reg : ram_q_reg;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= {dinReal, dinImag};
        ram_q_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        bypass_data_reg <= {dinReal, dinImag};
        if (!reset)
            bypass_reg <= 1'b0;
        else
            bypass_reg <= wr_en && (wr_ptr_reg == rd_ptr_reg);
    end

    always_comb begin
        occ_next = occ_reg;
        case ({wr_en, rd_en})
            2'b10:   occ_next = occ_reg + ADDR_WIDTH'(1);
            2'b01:   occ_next = occ_reg - ADDR_WIDTH'(1);
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            dec_cnt_reg    <= DC_W'(CLKS_PER_OUTPUT - 1);
            pilot_addr_reg <= '0;
            data_cnt_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            occ_reg        <= '0;
            full_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            clk_en_out_reg <= 1'b0;
            sof_reg        <= 1'b0;
            dout_re_reg    <= '0;
            dout_im_reg    <= '0;
        end else begin
            clk_en_out_reg <= strobe;
            occ_reg        <= occ_next;
            full_reg       <= (occ_next == {ADDR_WIDTH{1'b1}});
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
            if (rd_en)
                rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
            if (clkEn && valid && full_reg)
                overflow_reg <= 1'b1;

            if (clkEn) begin
                case (state_reg)
                    IDLE: begin
                        if (enable && (32'(occ_reg) >= PRIME_LEVEL)) begin
                            state_reg      <= PILOT;
                            pilot_addr_reg <= '0;
                            dec_cnt_reg    <= DC_W'(CLKS_PER_OUTPUT - 1);
                        end
                    end
                    PILOT, DATA: begin
                        if (dec_cnt_reg != '0) begin
                            dec_cnt_reg <= dec_cnt_reg - DC_W'(1);
                        end else begin
                            dec_cnt_reg <= DC_W'(CLKS_PER_OUTPUT - 1);
                            if (state_reg == PILOT) begin
                                dout_re_reg <= pilotReal;
                                dout_im_reg <= pilotImag;
                                sof_reg     <= (pilot_addr_reg == '0);
                                if (pilot_addr_reg == PA_W'(PILOT_LEN - 1)) begin
                                    pilot_addr_reg <= '0;
                                    data_cnt_reg   <= '0;
                                    state_reg      <= DATA;
                                end else begin
                                    pilot_addr_reg <= pilot_addr_reg + PA_W'(1);
                                end
                            end else begin
                                sof_reg <= 1'b0;
                                // A starved slot still consumes its place in the frame.
                                if (empty) begin
                                    dout_re_reg   <= '0;
                                    dout_im_reg   <= '0;
                                    underflow_reg <= 1'b1;
                                end else begin
                                    dout_re_reg <= head[35:18];
                                    dout_im_reg <= head[17:0];
                                end
                                if (data_cnt_reg == DN_W'(DATA_LEN - 1)) begin
                                    data_cnt_reg <= '0;
                                    state_reg    <= enable ? PILOT : IDLE;
                                end else begin
                                    data_cnt_reg <= data_cnt_reg + DN_W'(1);
                                end
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign pilotAddr    = pilot_addr_reg;
    assign clkEnOut     = clk_en_out_reg;
    assign startOfFrame = sof_reg;
    assign doutReal     = dout_re_reg;
    assign doutImag     = dout_im_reg;
    assign full         = full_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_stc_frame_assembler.sv
// Scoreboard bench for stc_frame_assembler: stimulus queues expected strobes, a monitor
// compares every clkEnOut strobe and its spacing; a small-FIFO instance covers full/overflow.
module tb_stc_frame_assembler;
    localparam int PL = 4, DL = 8, CPO = 4, PRIME = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0, clkEn = 1'b1, enable = 1'b0, valid = 1'b0, toggle = 1'b0;
    logic signed [17:0] dinReal = '0, dinImag = '0, pilotReal = '0, pilotImag = '0;
    logic [1:0] pilotAddr;
    logic clkEnOut, startOfFrame, full, overflow, underflow;
    logic signed [17:0] doutReal, doutImag;

    logic s_reset = 1'b0, s_valid = 1'b0;
    logic signed [17:0] s_din = '0;
    logic [1:0] s_pilot_addr;
    logic s_clk_en_out, s_sof, s_full, s_overflow, s_underflow;
    logic signed [17:0] s_dout_re, s_dout_im;

    stc_frame_assembler #(.PILOT_LEN(PL), .DATA_LEN(DL), .CLKS_PER_OUTPUT(CPO),
                          .ADDR_WIDTH(5), .PRIME_LEVEL(PRIME)) dut (
        .clk(clk), .reset(reset), .clkEn(clkEn), .enable(enable), .valid(valid),
        .dinReal(dinReal), .dinImag(dinImag), .pilotReal(pilotReal), .pilotImag(pilotImag),
        .pilotAddr(pilotAddr), .clkEnOut(clkEnOut), .startOfFrame(startOfFrame),
        .doutReal(doutReal), .doutImag(doutImag), .full(full), .overflow(overflow),
        .underflow(underflow));

    stc_frame_assembler #(.PILOT_LEN(PL), .DATA_LEN(DL), .CLKS_PER_OUTPUT(CPO),
                          .ADDR_WIDTH(4), .PRIME_LEVEL(PRIME)) dut_small (
        .clk(clk), .reset(s_reset), .clkEn(1'b1), .enable(1'b0), .valid(s_valid),
        .dinReal(s_din), .dinImag(s_din), .pilotReal(18'sd0), .pilotImag(18'sd0),
        .pilotAddr(s_pilot_addr), .clkEnOut(s_clk_en_out), .startOfFrame(s_sof),
        .doutReal(s_dout_re), .doutImag(s_dout_im), .full(s_full), .overflow(s_overflow),
        .underflow(s_underflow));

    // Pilot ROM model: ROM[n] = 100+n (I), 200+n (Q), one clock latency.
    always @(posedge clk) begin
        pilotReal <= 18'(100 + int'(pilotAddr));
        pilotImag <= 18'(200 + int'(pilotAddr));
    end

    initial forever begin
        @(posedge clk);
        #1;
        clkEn = toggle ? ~clkEn : 1'b1;
    end

    typedef struct packed {
        logic               sof;
        logic signed [17:0] re;
        logic signed [17:0] im;
        logic               uf;
        logic               contig;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0, errors = 0;
    int gap = 0;

    initial forever begin
        @(negedge clk);
        if (clkEnOut) begin
            $display("strobe: sof=%0b re=%0d im=%0d uf=%0b gap=%0d",
                     startOfFrame, doutReal, doutImag, underflow, gap);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got strobe re=%0d, required no strobe", doutReal);
            end else begin
                mon_e = sb.pop_front();
                if (startOfFrame !== mon_e.sof || doutReal !== mon_e.re ||
                    doutImag !== mon_e.im || underflow !== mon_e.uf) begin
                    errors++;
                    $display("FAIL strobe_data: got sof=%0b re=%0d im=%0d uf=%0b, required sof=%0b re=%0d im=%0d uf=%0b",
                             startOfFrame, doutReal, doutImag, underflow,
                             mon_e.sof, mon_e.re, mon_e.im, mon_e.uf);
                end
                if (mon_e.contig) begin
                    checks++;
                    if (gap != CPO) begin
                        errors++;
                        $display("FAIL strobe_spacing: got %0d clkEn cycles, required %0d", gap, CPO);
                    end
                end
            end
            gap = 0;
        end
        if (clkEn)
            gap++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push(input bit sof, input int re, input int im, input bit uf, input bit contig);
        exp_t e;
        e.sof = sof; e.re = 18'(re); e.im = 18'(im); e.uf = uf; e.contig = contig;
        sb.push_back(e);
    endtask

    // Pilots 100..103, then data first..first+7 (or zeros with underflow when starved).
    task automatic push_frame(input int first, input bit starve, input bit contig_first);
        for (int p = 0; p < PL; p++)
            push(p == 0, 100 + p, 200 + p, 1'b0, (p == 0) ? contig_first : 1'b1);
        for (int d = 0; d < DL; d++)
            if (starve) push(1'b0, 0, 0, 1'b1, 1'b1);
            else        push(1'b0, first + d, first + d + 500, 1'b0, 1'b1);
    endtask

    task automatic write_sample(input int n);
        logic en;
        valid = 1'b1; dinReal = 18'(n); dinImag = 18'(n + 500);
        do begin
            @(negedge clk);
            en = clkEn;
            tick();
        end while (!en);
        valid = 1'b0;
    endtask

    task automatic wait_queue(input string name, input int limit, input int budget);
        for (int i = 0; i < budget && sb.size() > limit; i++)
            tick();
        if (sb.size() > limit) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d pending strobes, required %0d", name, sb.size(), limit);
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) tick();
        check("reset_flags", int'({clkEnOut, startOfFrame, full, overflow, underflow, pilotAddr}), 0);
        check("reset_dout_re", int'(doutReal), 0);
        check("reset_dout_im", int'(doutImag), 0);
        reset = 1'b1;
        s_reset = 1'b1;
        tick();

        // Single frame.
        for (int n = 1; n <= 8; n++) write_sample(n);
        push_frame(1, 1'b0, 1'b0);
        enable = 1'b1; tick(); tick(); enable = 1'b0;
        wait_queue("t1_drain", 0, 300);
        repeat (10) tick();
        check("t1_pilot_addr_idle", int'(pilotAddr), 0);
        check("t1_underflow", int'(underflow), 0);

        // Back-to-back frames.
        for (int n = 1; n <= 16; n++) write_sample(n);
        push_frame(1, 1'b0, 1'b0);
        push_frame(9, 1'b0, 1'b1);
        enable = 1'b1;
        wait_queue("t2_frame2_start", 11, 300);
        enable = 1'b0;
        wait_queue("t2_drain", 0, 300);
        repeat (10) tick();

        // 50% clkEn duty.
        toggle = 1'b1;
        for (int n = 1; n <= 8; n++) write_sample(n);
        push_frame(1, 1'b0, 1'b0);
        enable = 1'b1; repeat (4) tick(); enable = 1'b0;
        wait_queue("t5_drain", 0, 600);
        toggle = 1'b0;
        repeat (10) tick();

        // Starvation in the second frame.
        for (int n = 1; n <= 8; n++) write_sample(n);
        push_frame(1, 1'b0, 1'b0);
        push_frame(0, 1'b1, 1'b1);
        enable = 1'b1;
        wait_queue("t3_frame2_start", 11, 300);
        enable = 1'b0;
        wait_queue("t3_drain", 0, 300);
        repeat (10) tick();
        check("t3_underflow_sticky", int'(underflow), 1);

        // Reset mid-pilot, then below-prime hold-off and a clean restart.
        reset = 1'b0; tick(); reset = 1'b1;
        for (int n = 1; n <= 8; n++) write_sample(n);
        push(1'b1, 100, 200, 1'b0, 1'b0);
        push(1'b0, 101, 201, 1'b0, 1'b1);
        enable = 1'b1;
        wait_queue("t6_pilots", 0, 100);
        tick();
        reset = 1'b0; enable = 1'b0;
        tick();
        check("t6_reset_flags", int'({clkEnOut, startOfFrame, full, overflow, underflow, pilotAddr}), 0);
        check("t6_reset_dout_re", int'(doutReal), 0);
        check("t6_reset_dout_im", int'(doutImag), 0);
        reset = 1'b1;
        enable = 1'b1;
        for (int n = 1; n <= 7; n++) write_sample(n);
        repeat (20) tick();
        check("t6_below_prime_addr", int'(pilotAddr), 0);
        push_frame(1, 1'b0, 1'b0);
        write_sample(8);
        tick(); tick(); enable = 1'b0;
        wait_queue("t6_drain", 0, 300);
        repeat (10) tick();

        // Full / overflow on the 16-entry FIFO.
        for (int n = 1; n <= 16; n++) begin
            s_valid = 1'b1; s_din = 18'(n);
            tick();
            if (n == 14) check("small_full_at_14", int'(s_full), 0);
            if (n == 15) begin
                check("small_full_at_15", int'(s_full), 1);
                check("small_overflow_at_15", int'(s_overflow), 0);
            end
            if (n == 16) begin
                check("small_overflow_at_16", int'(s_overflow), 1);
                check("small_full_at_16", int'(s_full), 1);
            end
        end
        s_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
